fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4, number of requesters sharing the FIFO write port.
REQ-003 Parameter MAX_BURST, default 8, maximum beats per locked burst; legal range 1..255.
REQ-004 wr_clk  in  1  sole clock, all state updates on rising edge.
REQ-005 res  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 req  in  NREQ  per-requester write request, held with data until granted.
REQ-007 req_last  in  NREQ  marks the requester's current beat as the final beat of its burst.
REQ-008 req_data  in  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
REQ-009 gnt  out  NREQ  one-hot accept; beat i transfers in any cycle with req[i]=1 and gnt[i]=1.
REQ-010 full  in  1  FIFO full flag, write-clock domain.
REQ-011 over_flow  in  1  FIFO overflow pulse, write-clock domain.
REQ-012 wr_en  out  1  FIFO write enable.
REQ-013 wdata  out  WIDTH  FIFO write data.
REQ-014 owner  out  clog2(NREQ)  index of the most recently granted requester.
REQ-015 busy  out  1  high while in LOCKED state.
REQ-016 ovf_cnt  out  16  saturating count of over_flow pulses.

Function
REQ-017 gnt, wr_en and wdata SHALL be combinational from current state, req, req_last, full and res; all other state SHALL be registered.
REQ-018 wr_en SHALL equal OR of gnt; wdata SHALL equal req_data of the granted requester, and 0 when wr_en=0.
REQ-019 No gnt bit SHALL be high while full=1 or res=1; at most one gnt bit SHALL be high per cycle.
REQ-020 States SHALL be IDLE and LOCKED; registers rr_ptr (clog2(NREQ)), owner, beat_cnt (8 bits).
REQ-021 IDLE, full=0, any req: winner = first i with req[i]=1 searching rr_ptr, rr_ptr+1, ... mod NREQ; gnt[winner]=1.
REQ-022 On an IDLE grant, owner SHALL load winner; if req_last[winner]=1 or MAX_BURST=1, next state IDLE and rr_ptr <= (winner+1) mod NREQ; otherwise next state LOCKED, beat_cnt <= 1.
REQ-023 IDLE with full=1 or no req: no grant, all registers hold.
REQ-024 LOCKED: gnt[owner] = req[owner] AND NOT full; all other gnt bits SHALL be 0 regardless of their req.
REQ-025 LOCKED grant: if req_last[owner]=1 or beat_cnt = MAX_BURST-1, next state IDLE, rr_ptr <= (owner+1) mod NREQ, beat_cnt <= 0; otherwise beat_cnt increments.
REQ-026 LOCKED with req[owner]=0 or full=1: no grant, state and beat_cnt hold (bubble, lock retained).
REQ-027 A burst SHALL never exceed MAX_BURST granted beats.
REQ-028 busy SHALL be 1 exactly when state is LOCKED.
REQ-029 ovf_cnt SHALL increment by 1 on each cycle over_flow=1, saturating at 16'hFFFF.
REQ-030 Requests arriving while full=1 SHALL be arbitrated normally on the first cycle full=0, without lost priority order.

Reset
REQ-031 res=1 at a rising edge SHALL set state IDLE, rr_ptr 0, owner 0, beat_cnt 0, ovf_cnt 0.
REQ-032 While res=1, gnt SHALL be 0, wr_en 0, wdata 0, busy follows registered state (0 after first reset edge).
REQ-033 Reset asserted mid-burst SHALL abort the lock; the first grant after release follows REQ-021 from rr_ptr 0.

Verification
REQ-034 Reset, then req=4'b1111, req_last=4'b1111, full=0 for 4 cycles -> gnt 0001,0010,0100,1000; wr_en=1 each cycle; wdata matches each requester.
REQ-035 req[2]=1, req_last=0, req[0]=1 held, MAX_BURST=8 -> gnt[2] for 8 consecutive cycles, busy=1 during beats 2..8, then gnt[0] next.
REQ-036 Burst on requester 1 with req_last on beat 3 -> exactly 3 beats granted, state returns IDLE, rr_ptr=2.
REQ-037 full=1 for 5 cycles with req=4'b0110 -> gnt=0, wr_en=0 throughout; full=0 -> gnt=0010 on that cycle.
REQ-038 LOCKED owner 3, req[3] drops 2 cycles while req[0]=1 -> no grant for 2 cycles, lock retained, then gnt[3] resumes.
REQ-039 over_flow pulsed 3 times -> ovf_cnt=3; res=1 mid-burst -> busy=0, ovf_cnt=0, gnt=0 next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one FIFO write port among NREQ requesters. In IDLE a round-robin
//   search starting at rr_ptr picks the winner; a grant without req_last
//   locks the port to that requester for up to MAX_BURST beats.
// Ports
//   wr_clk, res        : clock, synchronous active-high reset
//   req/req_last       : per-requester request and end-of-burst flag
//   req_data           : requester i data on [i*WIDTH +: WIDTH]
//   full, over_flow    : FIFO status (write-clock domain)
//   gnt, wr_en, wdata  : combinational accept and FIFO write port
//   owner, busy        : last granted requester, LOCKED indicator
//   ovf_cnt            : saturating overflow pulse count
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 8,
   localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    wr_clk,
   input  logic                    res,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   input  logic                    full,
   input  logic                    over_flow,
   output logic [NREQ-1:0]         gnt,
   output logic                    wr_en,
   output logic [WIDTH-1:0]        wdata,
   output logic [PW-1:0]           owner,
   output logic                    busy,
   output logic [15:0]             ovf_cnt
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_rr_ptr;
   logic [PW-1:0]   r_owner;
   logic [7:0]      r_beat_cnt;
   logic [15:0]     r_ovf_cnt;

   logic [PW-1:0]   w_winner;
   logic            w_any;
   logic [PW-1:0]   w_gidx;
   logic [NREQ-1:0] w_gnt;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (i == PW'(NREQ-1)) ? '0 : i + PW'(1);
   endfunction

   // Round-robin search: walk offsets high to low so the smallest offset
   // from rr_ptr overwrites and wins.
   always_comb begin
      w_any    = |req;
      w_winner = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % NREQ;
         if (req[idx]) w_winner = PW'(idx);
      end
   end

   always_comb begin
      w_gnt  = '0;
      w_gidx = (r_state == S_IDLE) ? w_winner : r_owner;
      if (!res && !full) begin
         if (r_state == S_IDLE) begin
            if (w_any) w_gnt[w_winner] = 1'b1;
         end else begin
            // Lock: only the owner may write, others wait regardless of req.
            w_gnt[r_owner] = req[r_owner];
         end
      end
   end

   assign gnt     = w_gnt;
   assign wr_en   = |w_gnt;
   assign wdata   = wr_en ? req_data[w_gidx*WIDTH +: WIDTH] : '0;
   assign owner   = r_owner;
   assign busy    = (r_state == S_LOCKED);
   assign ovf_cnt = r_ovf_cnt;

   always_ff @(posedge wr_clk) begin
      if (res) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_beat_cnt <= '0;
         r_ovf_cnt  <= '0;
      end else begin
         if (over_flow && (r_ovf_cnt != 16'hFFFF))
            r_ovf_cnt <= r_ovf_cnt + 16'd1;

         case (r_state)
            S_IDLE: begin
               if (wr_en) begin
                  r_owner <= w_winner;
                  if (req_last[w_winner] || (MAX_BURST == 1)) begin
                     r_rr_ptr <= next_idx(w_winner);
                  end else begin
                     r_state    <= S_LOCKED;
                     r_beat_cnt <= 8'd1;
                  end
               end
            end
            S_LOCKED: begin
               // No grant (owner idle or FIFO full) is a bubble: lock kept.
               if (wr_en) begin
                  if (req_last[r_owner] || (r_beat_cnt == 8'(MAX_BURST-1))) begin
                     r_state    <= S_IDLE;
                     r_rr_ptr   <= next_idx(r_owner);
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 8'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: stimulus pushes the expected grant per cycle, a monitor
// thread pops and compares whenever wr_en is high or an entry is due.
module tb_fifo_wr_arbiter;

   logic        wr_clk = 1'b0;
   logic        res = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  req_last = '0;
   logic [31:0] req_data = {8'h44, 8'h33, 8'h22, 8'h11};
   logic        full = 1'b0;
   logic        over_flow = 1'b0;
   logic [3:0]  gnt;
   logic        wr_en;
   logic [7:0]  wdata;
   logic [1:0]  owner;
   logic        busy;
   logic [15:0] ovf_cnt;

   fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(8)) dut (
      .wr_clk(wr_clk), .res(res), .req(req), .req_last(req_last),
      .req_data(req_data), .full(full), .over_flow(over_flow),
      .gnt(gnt), .wr_en(wr_en), .wdata(wdata), .owner(owner),
      .busy(busy), .ovf_cnt(ovf_cnt)
   );

   always #5 wr_clk = ~wr_clk;

   typedef struct {
      int         cyc;
      logic [3:0] g;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;
   bit   done   = 0;

   function automatic logic [7:0] edata(input logic [3:0] g);
      case (g)
         4'b0001: return 8'h11;
         4'b0010: return 8'h22;
         4'b0100: return 8'h33;
         4'b1000: return 8'h44;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // One bus cycle: drive after the rising edge, record the expected grant,
   // return at the falling edge so callers can check registered outputs.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic f,
                      input logic o, input logic rs, input logic [3:0] eg);
      @(posedge wr_clk);
      #1;
      req = r; req_last = l; full = f; over_flow = o; res = rs;
      cyc_n++;
      if (eg != 4'b0000) sb.push_back('{cyc: cyc_n, g: eg, d: edata(eg)});
      @(negedge wr_clk);
   endtask

   initial begin
      fork
         begin : monitor
            while (!done) begin
               @(negedge wr_clk);
               if (wr_en) begin
                  if (sb.size() == 0 || sb[0].cyc != cyc_n) begin
                     chk("unexpected_grant", int'(gnt), 0);
                  end else begin
                     exp_t e;
                     e = sb.pop_front();
                     chk("gnt", int'(gnt), int'(e.g));
                     chk("wdata", int'(wdata), int'(e.d));
                  end
               end else if (sb.size() != 0 && sb[0].cyc == cyc_n) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("missing_grant", int'(gnt), int'(e.g));
               end else begin
                  chk("idle_wdata", int'(wdata), 0);
               end
            end
         end
         begin : stim
            // reset with requests present: no grant allowed
            cyc(4'b1111, 4'b1111, 0, 0, 1, 4'b0000);
            cyc(4'b1111, 4'b1111, 0, 0, 1, 4'b0000);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ovf", int'(ovf_cnt), 0);
            chk("rst_owner", int'(owner), 0);

            // round robin over single-beat requests
            cyc(4'b1111, 4'b1111, 0, 0, 0, 4'b0001);
            cyc(4'b1111, 4'b1111, 0, 0, 0, 4'b0010);
            cyc(4'b1111, 4'b1111, 0, 0, 0, 4'b0100);
            cyc(4'b1111, 4'b1111, 0, 0, 0, 4'b1000);
            chk("rr_busy", int'(busy), 0);

            // MAX_BURST cut-off on requester 2 while requester 0 waits
            cyc(4'b0100, 4'b0000, 0, 0, 0, 4'b0100);
            chk("b8_busy_beat1", int'(busy), 0);
            chk("b8_owner", int'(owner), 3);
            for (int i = 0; i < 7; i++) begin
               cyc(4'b0101, 4'b0000, 0, 0, 0, 4'b0100);
               chk("b8_busy", int'(busy), 1);
            end
            cyc(4'b0101, 4'b0001, 0, 0, 0, 4'b0001);
            chk("b8_after_busy", int'(busy), 0);

            // req_last on beat 3 of a requester-1 burst
            cyc(4'b0010, 4'b0000, 0, 0, 0, 4'b0010);
            cyc(4'b0010, 4'b0000, 0, 0, 0, 4'b0010);
            chk("last_busy2", int'(busy), 1);
            cyc(4'b0010, 4'b0010, 0, 0, 0, 4'b0010);
            chk("last_busy3", int'(busy), 1);
            cyc(4'b1111, 4'b1111, 0, 0, 0, 4'b0100);  // rr_ptr must be 2
            chk("last_busy_end", int'(busy), 0);
            chk("last_owner", int'(owner), 1);

            // full blocks everything; release arbitrates from rr_ptr 3
            for (int i = 0; i < 5; i++)
               cyc(4'b0110, 4'b0110, 1, 0, 0, 4'b0000);
            cyc(4'b0110, 4'b0110, 0, 0, 0, 4'b0010);

            // owner 3 drops req for two cycles; lock kept
            cyc(4'b1000, 4'b0000, 0, 0, 0, 4'b1000);
            cyc(4'b0001, 4'b0000, 0, 0, 0, 4'b0000);
            chk("bubble_busy1", int'(busy), 1);
            cyc(4'b0001, 4'b0000, 0, 0, 0, 4'b0000);
            chk("bubble_busy2", int'(busy), 1);
            cyc(4'b1001, 4'b1000, 0, 0, 0, 4'b1000);
            chk("bubble_owner", int'(owner), 3);
            cyc(4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
            chk("bubble_end_busy", int'(busy), 0);

            // overflow counting
            for (int i = 0; i < 3; i++)
               cyc(4'b0000, 4'b0000, 0, 1, 0, 4'b0000);
            cyc(4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
            chk("ovf_cnt3", int'(ovf_cnt), 3);

            // reset mid-burst
            cyc(4'b0100, 4'b0000, 0, 0, 0, 4'b0100);
            cyc(4'b0100, 4'b0000, 0, 0, 0, 4'b0100);
            chk("mid_busy", int'(busy), 1);
            cyc(4'b0100, 4'b0000, 0, 0, 1, 4'b0000);
            chk("rst_cyc_busy", int'(busy), 1);
            cyc(4'b0011, 4'b0011, 0, 0, 0, 4'b0001);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_ovf", int'(ovf_cnt), 0);
            cyc(4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
            chk("post_rst_owner", int'(owner), 0);
            done = 1;
         end
      join
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
